drive_command_fsm: RTL and testbench

DRIVE_COMMAND_FSM -- requirements
Module: drive_command_fsm

---
 rtl/drive_command_fsm.sv | 166 ++++++++++++++++
 tb/tb_drive_command_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_command_fsm.sv
// Drive command state machine: turns debounced audio, ultrasonic obstacle and
// red-target inputs into a direction, ramped speed and supervisory state.
module drive_command_fsm #(
    parameter int unsigned FREQ_W       = 10,
    parameter int unsigned DIST_W       = 8,
    parameter int unsigned PIX_W        = 17,
    parameter int unsigned SPEED_W      = 3,
    parameter int unsigned TOO_CLOSE    = 20,
    parameter int unsigned CLEAR_MARGIN = 5,
    parameter int unsigned RED_MIN      = 1000,
    parameter int unsigned PERSIST      = 3,
    parameter int unsigned RAMP_TICKS   = 2500000,
    parameter int unsigned SEEK_SPEED   = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [FREQ_W-1:0]  mic_freq,
    input  logic               mic_valid,
    input  logic [DIST_W-1:0]  distance,
    input  logic               dist_valid,
    input  logic [PIX_W-1:0]   red_pixels,
    input  logic               frame_done,
    input  logic [4:0]         threshold_frequency,
    output logic [2:0]         direction,
    output logic [SPEED_W-1:0] speed,
    output logic               obstacle,
    output logic               cmd_go,
    output logic [1:0]         state
);

    localparam int unsigned PCNT_W    = $clog2(PERSIST + 1);
    localparam int unsigned RAMP_W    = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int unsigned MAX_SPEED = (1 << SPEED_W) - 1;

    typedef enum logic [1:0] {
        S_STOP    = 2'd0,
        S_FWD     = 2'd1,
        S_BLOCKED = 2'd2,
        S_SEEK    = 2'd3
    } state_t;

    localparam logic [2:0] DIR_STOP    = 3'd0;
    localparam logic [2:0] DIR_FORWARD = 3'd1;
    localparam logic [2:0] DIR_LEFT    = 3'd3;

    state_t              cur_state, next_state;
    logic                go_q, obs_q, lock_q;
    logic [PCNT_W-1:0]   pcnt_q;
    logic [FREQ_W-1:0]   mic_q;
    logic [FREQ_W-1:0]   thr;
    logic [FREQ_W-1:0]   diff;
    int unsigned         steps;
    logic [SPEED_W-1:0]  target;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [RAMP_W-1:0]   ramp_q, ramp_d;
    logic [2:0]          dir_q, dir_d;

    assign thr = FREQ_W'({threshold_frequency, 4'b0000});

    // Sensor conditioning: pitch debounce, obstacle hysteresis, target lock.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            go_q   <= 1'b0;
            pcnt_q <= '0;
            mic_q  <= '0;
            obs_q  <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            if (mic_valid) begin
                mic_q <= mic_freq;
                if ((mic_freq >= thr) != go_q) begin
                    if (32'(pcnt_q) == PERSIST - 1) begin
                        go_q   <= ~go_q;
                        pcnt_q <= '0;
                    end else begin
                        pcnt_q <= pcnt_q + PCNT_W'(1);
                    end
                end else begin
                    pcnt_q <= '0;
                end
            end
            if (dist_valid && distance != '0) begin
                if (32'(distance) < TOO_CLOSE)
                    obs_q <= 1'b1;
                else if (32'(distance) >= TOO_CLOSE + CLEAR_MARGIN)
                    obs_q <= 1'b0;
            end
            if (frame_done)
                lock_q <= (32'(red_pixels) >= RED_MIN);
        end
    end

    always_comb begin
        target = '0;
        diff   = mic_q - thr;
        steps  = 32'(diff >> 5) + 1;
        if (mic_q >= thr)
            target = (steps > MAX_SPEED) ? SPEED_W'(MAX_SPEED) : SPEED_W'(steps);
    end

    always_comb begin
        next_state = S_FWD;
        dir_d      = DIR_FORWARD;
        speed_d    = '0;
        ramp_d     = '0;

        if (!enable || mode == 2'd3 || !go_q)
            next_state = S_STOP;
        else if (obs_q && mode != 2'd0)
            next_state = S_BLOCKED;
        else if (!lock_q && mode == 2'd2)
            next_state = S_SEEK;

        case (next_state)
            S_SEEK: begin
                dir_d   = DIR_LEFT;
                speed_d = SPEED_W'(SEEK_SPEED);
            end
            S_FWD: begin
                dir_d = DIR_FORWARD;
                if (cur_state != S_FWD) begin
                    speed_d = SPEED_W'(1);
                end else begin
                    speed_d = speed_q;
                    // One step toward target per ramp period; the counter restarts each period.
                    if (ramp_q == RAMP_W'(RAMP_TICKS - 1)) begin
                        ramp_d = '0;
                        if (speed_q < target)
                            speed_d = speed_q + SPEED_W'(1);
                        else if (speed_q > target)
                            speed_d = speed_q - SPEED_W'(1);
                    end else begin
                        ramp_d = ramp_q + RAMP_W'(1);
                    end
                end
            end
            default: begin
                dir_d   = DIR_STOP;
                speed_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur_state <= S_STOP;
            dir_q     <= DIR_STOP;
            speed_q   <= '0;
            ramp_q    <= '0;
        end else begin
            cur_state <= next_state;
            dir_q     <= dir_d;
            speed_q   <= speed_d;
            ramp_q    <= ramp_d;
        end
    end

    assign state     = cur_state;
    assign direction = dir_q;
    assign speed     = speed_q;
    assign obstacle  = obs_q;
    assign cmd_go    = go_q;

endmodule

// File: tb/tb_drive_command_fsm.sv
// Bench for drive_command_fsm: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_drive_command_fsm;

    localparam int RT      = 4;
    localparam int PERSIST = 3;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] mic_freq = '0;
    logic       mic_valid = 1'b0;
    logic [7:0] distance = '0;
    logic       dist_valid = 1'b0;
    logic [16:0] red_pixels = '0;
    logic       frame_done = 1'b0;
    logic [4:0] threshold_frequency = '0;
    logic [2:0] direction;
    logic [2:0] speed;
    logic       obstacle;
    logic       cmd_go;
    logic [1:0] state;

    always #5 CLOCK_50 = ~CLOCK_50;

    drive_command_fsm #(.RAMP_TICKS(RT)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .mode(mode),
        .mic_freq(mic_freq), .mic_valid(mic_valid), .distance(distance),
        .dist_valid(dist_valid), .red_pixels(red_pixels), .frame_done(frame_done),
        .threshold_frequency(threshold_frequency), .direction(direction),
        .speed(speed), .obstacle(obstacle), .cmd_go(cmd_go), .state(state)
    );

    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: command/obstacle/lock flags plus the motion it implies.
    int m_go, m_cnt, m_obs, m_lock, m_mic, m_state, m_dir, m_speed, m_ramp;
    int dir_of[4]   = '{0, 1, 0, 3};
    int fixed_spd[4] = '{0, 0, 0, 2};

    task automatic model_reset();
        m_go = 0; m_cnt = 0; m_obs = 0; m_lock = 0; m_mic = 0;
        m_state = 0; m_dir = 0; m_speed = 0; m_ramp = 0;
    endtask

    task automatic model_step();
        int thr, ns, tgt, cls;
        if (reset) begin
            model_reset();
            return;
        end
        thr = int'(threshold_frequency) * 16;
        if (!enable || mode == 3 || m_go == 0)       ns = 0;
        else if (m_obs != 0 && mode != 0)           ns = 2;
        else if (m_lock == 0 && mode == 2)          ns = 3;
        else                                        ns = 1;
        if (m_mic < thr) tgt = 0;
        else begin
            tgt = 1 + (m_mic - thr) / 32;
            if (tgt > 7) tgt = 7;
        end
        if (ns != m_state) begin
            m_ramp  = 0;
            m_speed = (ns == 1) ? 1 : fixed_spd[ns];
        end else if (ns == 1) begin
            if (m_ramp == RT - 1) begin
                m_ramp = 0;
                if (m_speed < tgt) m_speed++;
                else if (m_speed > tgt) m_speed--;
            end else m_ramp++;
        end else begin
            m_ramp  = 0;
            m_speed = fixed_spd[ns];
        end
        m_state = ns;
        m_dir   = dir_of[ns];

        if (mic_valid) begin
            m_mic = int'(mic_freq);
            cls = (m_mic >= thr) ? 1 : 0;
            if (cls != m_go) begin
                m_cnt++;
                if (m_cnt == PERSIST) begin
                    m_go  = 1 - m_go;
                    m_cnt = 0;
                end
            end else m_cnt = 0;
        end
        if (dist_valid && distance != 0) begin
            if (distance < 20) m_obs = 1;
            else if (distance >= 25) m_obs = 0;
        end
        if (frame_done) m_lock = (red_pixels >= 1000) ? 1 : 0;
    endtask

    always @(negedge CLOCK_50) begin
        if (run_chk) begin
            check("state", int'(state), m_state);
            check("direction", int'(direction), m_dir);
            check("speed", int'(speed), m_speed);
            check("obstacle", int'(obstacle), m_obs);
            check("cmd_go", int'(cmd_go), m_go);
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        #1;
        mic_valid  = 1'b0;
        dist_valid = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic mic_send(input int f);
        mic_freq  = 10'(f);
        mic_valid = 1'b1;
        tick();
    endtask

    task automatic dist_send(input int d);
        distance   = 8'(d);
        dist_valid = 1'b1;
        tick();
    endtask

    task automatic frame_send(input int p);
        red_pixels = 17'(p);
        frame_done = 1'b1;
        tick();
    endtask

    initial begin
        int thr_r;
        bit bias;
        model_reset();
        #1 reset = 1'b1;
        tick();
        run_chk = 1'b1;
        tick();
        check("rst_state", int'(state), 0);
        check("rst_speed", int'(speed), 0);
        check("rst_go", int'(cmd_go), 0);
        reset = 1'b0;
        enable = 1'b1;
        threshold_frequency = 5'd5;
        mode = 2'd0;

        // Audio start and ramp to target 4.
        repeat (3) mic_send(200);
        check("go_after3", int'(cmd_go), 1);
        check("still_stop", int'(state), 0);
        tick();
        check("fwd_state", int'(state), 1);
        check("fwd_dir", int'(direction), 1);
        check("fwd_speed1", int'(speed), 1);
        repeat (11) tick();
        check("ramp_speed3", int'(speed), 3);
        tick();
        check("ramp_speed4", int'(speed), 4);

        // Obstacle hysteresis.
        mode = 2'd1;
        dist_send(15);
        check("obs_set", int'(obstacle), 1);
        check("obs_latency", int'(state), 1);
        tick();
        check("blocked", int'(state), 2);
        check("blocked_speed", int'(speed), 0);
        dist_send(22);
        tick();
        check("hold_blocked", int'(state), 2);
        check("hold_obs", int'(obstacle), 1);
        dist_send(25);
        check("obs_clear", int'(obstacle), 0);
        tick();
        check("unblocked", int'(state), 1);
        check("unblocked_speed", int'(speed), 1);

        // Colour seek.
        frame_send(1200);
        mode = 2'd2;
        tick();
        check("locked_fwd", int'(state), 1);
        frame_send(500);
        tick();
        check("seek_state", int'(state), 3);
        check("seek_dir", int'(direction), 3);
        check("seek_speed", int'(speed), 2);
        frame_send(1200);
        tick();
        check("relock_fwd", int'(state), 1);
        check("relock_speed", int'(speed), 1);

        // Debounce on the way down.
        mode = 2'd0;
        mic_send(10);
        mic_send(10);
        mic_send(200);
        check("go_kept", int'(cmd_go), 1);
        tick();
        check("go_kept_fwd", int'(state), 1);
        repeat (3) mic_send(10);
        check("go_dropped", int'(cmd_go), 0);
        tick();
        check("drop_stop", int'(state), 0);
        check("drop_speed", int'(speed), 0);

        // Asynchronous reset mid-ramp.
        repeat (3) mic_send(200);
        tick();
        repeat (8) tick();
        tick();
        tick();
        check("pre_rst_speed", int'(speed), 3);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_state", int'(state), 0);
        check("async_speed", int'(speed), 0);
        check("async_dir", int'(direction), 0);
        check("async_go", int'(cmd_go), 0);
        check("async_obs", int'(obstacle), 0);
        tick();
        tick();
        reset = 1'b0;

        // Reserved mode stops a moving vehicle.
        repeat (3) mic_send(200);
        tick();
        check("mode3_pre", int'(state), 1);
        mode = 2'd3;
        tick();
        check("mode3_stop", int'(state), 0);
        check("mode3_speed", int'(speed), 0);

        // Randomized traffic.
        thr_r = 5;
        bias  = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            int r;
            if (i % 500 == 0) thr_r = $urandom_range(0, 31);
            if (i % 48 == 0) bias = ($urandom_range(0, 1) == 1);
            threshold_frequency = 5'(thr_r);
            reset  = ($urandom_range(0, 699) == 0);
            enable = ($urandom_range(0, 19) != 0);
            r = $urandom_range(0, 7);
            mode = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            if (i % 16 != 0) mode = mode;
            mic_valid = ($urandom_range(0, 2) == 0);
            if (bias) mic_freq = 10'(thr_r * 16 + $urandom_range(0, 255));
            else mic_freq = 10'($urandom_range(0, thr_r * 16));
            dist_valid = ($urandom_range(0, 3) == 0);
            distance   = 8'($urandom_range(0, 40));
            frame_done = ($urandom_range(0, 9) == 0);
            red_pixels = 17'($urandom_range(500, 1500));
            tick();
        end
        reset = 1'b0;
        tick();

        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
